// File: rtl/mod_sub.sv
// Modular subtractor (op1 - op2) mod Q for ML-KEM coefficients, canonical result in [0, Q-1].
// Define MOD_SUB_OUT_REG_EN to add one output register stage (1-cycle latency, sync active-low reset).
module mod_sub #(
    parameter int unsigned Q     = 3329,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    output logic             range_err_o
);

    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);

    logic             op1_big, op2_big;
    logic [WIDTH-1:0] a_norm, b_norm;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result_d;
    logic             range_err_d;

    always_comb begin
        op1_big = (op1_i >= QW);
        op2_big = (op2_i >= QW);
        a_norm  = op1_big ? (op1_i - QW) : op1_i;
        b_norm  = op2_big ? (op2_i - QW) : op2_i;
        diff    = {1'b0, a_norm} - {1'b0, b_norm};
        // A borrow means a negative difference; adding Q in WIDTH bits wraps it into [1, Q-1].
        result_d    = diff[WIDTH] ? (diff[WIDTH-1:0] + QW) : diff[WIDTH-1:0];
        range_err_d = valid_i & (op1_big | op2_big);
    end

`ifdef MOD_SUB_OUT_REG_EN
    logic [WIDTH-1:0] result_q;
    logic             range_err_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            range_err_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                result_q    <= result_d;
                range_err_q <= range_err_d;
            end
        end
    end

    assign result_o    = result_q;
    assign range_err_o = range_err_q;
    assign valid_o     = valid_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign result_o    = result_d;
    assign range_err_o = range_err_d;
    assign valid_o     = valid_i;
`endif

endmodule

// File: tb/tb_mod_sub.sv
// Self-checking bench for mod_sub: directed vector table, random in-range pairs,
// and registered-build reset/hold sequences when MOD_SUB_OUT_REG_EN is defined.
module tb_mod_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [11:0] op1_i = '0;
    logic [11:0] op2_i = '0;
    logic [11:0] result_o;
    logic        valid_o;
    logic        range_err_o;

    int checks = 0;
    int errors = 0;

    // Expected registered-output state: last values loaded on a valid cycle.
    int held_r = 0;
    int held_e = 0;

    mod_sub #(.Q(3329), .WIDTH(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .op1_i      (op1_i),
        .op2_i      (op2_i),
        .result_o   (result_o),
        .valid_o    (valid_o),
        .range_err_o(range_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v;
        int   a;
        int   b;
        int   exp_r;
        int   exp_e;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int a, input int b);
        @(negedge clk);
        valid_i = v;
        op1_i   = 12'(a);
        op2_i   = 12'(b);
    endtask

    task automatic settle();
`ifdef MOD_SUB_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    // Apply one operand pair and compare against its combinational expectation,
    // translated through the hold model in the registered build.
    task automatic apply_check(input string name, input logic v, input int a, input int b,
                               input int exp_r, input int exp_e);
        int er;
        int ee;
        drive(v, a, b);
        settle();
`ifdef MOD_SUB_OUT_REG_EN
        if (v) begin
            held_r = exp_r;
            held_e = exp_e;
        end
        er = held_r;
        ee = held_e;
`else
        er = exp_r;
        ee = exp_e;
`endif
        chk({name, "_res"}, int'(result_o), er);
        chk({name, "_err"}, int'(range_err_o), ee);
        chk({name, "_vld"}, int'(valid_o), int'(v));
    endtask

    initial begin
        int a;
        int b;
        int exp_r;

        vecs[0]  = '{1'b1,   50,   20,   30, 0};
        vecs[1]  = '{1'b1,   20,   50, 3299, 0};
        vecs[2]  = '{1'b1,    0,    1, 3328, 0};
        vecs[3]  = '{1'b1, 3328,    0, 3328, 0};
        vecs[4]  = '{1'b1,  100,  100,    0, 0};
        vecs[5]  = '{1'b1,    0, 3328,    1, 0};
        vecs[6]  = '{1'b1, 1664, 1665, 3328, 0};
        vecs[7]  = '{1'b1, 4095,    0,  766, 1};
        vecs[8]  = '{1'b1,    0, 3329,    0, 1};
        vecs[9]  = '{1'b1,    0, 4095, 2563, 1};
        vecs[10] = '{1'b0, 4095,    0,  766, 0};
        vecs[11] = '{1'b0,    0, 3329,    0, 0};

`ifdef MOD_SUB_OUT_REG_EN
        // Reset held for 3 cycles with valid out-of-range operands: outputs must stay 0.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4095, 0);
            settle();
            chk($sformatf("rst%0d_res", i), int'(result_o), 0);
            chk($sformatf("rst%0d_err", i), int'(range_err_o), 0);
            chk($sformatf("rst%0d_vld", i), int'(valid_o), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply_check("rst_release", 1'b1, 5, 7, 3327, 0);
`else
        // Combinational path ignores reset.
        rst_n = 1'b0;
        apply_check("in_reset", 1'b1, 50, 20, 30, 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        for (int i = 0; i < 12; i++) begin
            apply_check($sformatf("vec%0d", i), vecs[i].v, vecs[i].a, vecs[i].b,
                        vecs[i].exp_r, vecs[i].exp_e);
        end

        // Hold behaviour: an invalid cycle keeps the registered result.
        apply_check("hold_a", 1'b1, 9, 4, 5, 0);
        apply_check("hold_b", 1'b0, 1, 2, 3328, 0);

`ifdef MOD_SUB_OUT_REG_EN
        // Mid-stream reset drops that cycle's operands; stream resumes next cycle.
        apply_check("ms_pre", 1'b1, 10, 3, 7, 0);
        drive(1'b1, 20, 1);
        rst_n = 1'b0;
        settle();
        held_r = 0;
        held_e = 0;
        chk("ms_rst_res", int'(result_o), 0);
        chk("ms_rst_err", int'(range_err_o), 0);
        chk("ms_rst_vld", int'(valid_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_check("ms_post", 1'b1, 30, 40, 3319, 0);
`endif

        for (int i = 0; i < 10000; i++) begin
            a = int'($urandom_range(0, 3328));
            b = int'($urandom_range(0, 3328));
            exp_r = (a - b + 3329) % 3329;
            drive(1'b1, a, b);
            settle();
            checks++;
            if (int'(result_o) != exp_r || range_err_o !== 1'b0 || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL rand a=%0d b=%0d actual=%0d/%0b/%0b expected=%0d/0/1",
                         a, b, result_o, range_err_o, valid_o, exp_r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
